// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer sequencer.
//   buzz_state_t : sequencer states (IDLE, ON, OFF)
//   ADDR_*       : Avalon register addresses
//   CTRL_*       : bit positions of CTRL write commands
//   RD_*         : bit positions of CTRL read status
package buzz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } buzz_state_t;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_ON   = 2'd1;
    localparam logic [1:0] ADDR_OFF  = 2'd2;
    localparam logic [1:0] ADDR_REP  = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_DONE_CLR = 3;

    localparam int RD_BUSY   = 0;
    localparam int RD_IRQ_EN = 2;
    localparam int RD_DONE   = 3;

endpackage

// File: rtl/buzz_sequencer_if.sv
// Avalon-MM slave bus bundle for the buzzer sequencer.
//   address[1:0]    : register select
//   chipselect      : slave select
//   write_n         : active-low write strobe
//   writedata[31:0] : write data
//   readdata[31:0]  : read data (combinational from address, zero wait states)
// Modports: master (CPU side), slave (sequencer side).
interface buzz_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/buzz_tick_div.sv
// Clear-able clock divider producing a one-cycle pulse every DIV cycles.
//   clk   : system clock
//   reset : synchronous active-high reset
//   clear : hold/restart the count at zero
//   pulse : high during the last cycle of each DIV-cycle period
// The pulse is decoded from the count alone (not gated by clear) so that
// callers can derive clear from pulse without forming a combinational loop.
module buzz_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pulse
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign pulse = (count == CW'(DIV - 1));

    // Free-running modulo-DIV counter; clear forces it back to zero so a
    // new period always starts a full DIV cycles before its first pulse.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (pulse) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/buzz_sequencer.sv
// Avalon-MM buzzer cadence sequencer.
// Software programs ON_TICKS, OFF_TICKS and REPEAT, then writes START; the
// block plays REPEAT on/off patterns (0 = forever) and raises a sticky done
// flag, optionally as a level interrupt.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   bus      : Avalon-MM slave (buzz_sequencer_if.slave)
//   out_port : [0] tone, [1] envelope
//   irq      : done & irq_en
// Optional feature macro BUZZ_TONE_EN: when defined, out_port[0] is a square
// wave of half-period TONE_HALF during ON (passive piezo); when undefined,
// out_port[0] simply follows the envelope (active buzzer).
module buzz_sequencer
    import buzz_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int TONE_HALF = 12500,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    buzz_sequencer_if.slave       bus,
    output logic [1:0]            out_port,
    output logic                  irq
);

    buzz_state_t      state;
    logic [CNT_W-1:0] on_ticks;
    logic [CNT_W-1:0] off_ticks;
    logic [CNT_W-1:0] rep_ticks;
    logic             irq_en;
    logic             done;

    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] phase_cnt;
    logic             env;

    logic             wr_en;
    logic             ctrl_wr;
    logic             stop_req;
    logic             start_req;
    logic             tick;
    logic             tick_clear;
    logic [CNT_W-1:0] cur_len;
    logic             phase_last;
    logic             seq_done;
    logic             go_on;
    logic             go_off;
    logic             go_idle;
    logic [31:0]      rdata;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata[31:CNT_W];

    // Bus decode: STOP beats START when both are written together.
    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign ctrl_wr   = wr_en & (bus.address == ADDR_CTRL);
    assign stop_req  = ctrl_wr & bus.writedata[CTRL_STOP];
    assign start_req = ctrl_wr & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_STOP];

    // Phase bookkeeping: a phase ends on the tick that completes its last
    // tick period. Lengths are latched at ON entry, never zero.
    assign cur_len    = (state == ON) ? on_len : off_len;
    assign phase_last = tick & (state != IDLE) & (phase_cnt == (cur_len - CNT_W'(1)));

    // Next-state decisions. Any bus command overrides the natural cadence.
    assign seq_done = (state == OFF) & phase_last & (rem == CNT_W'(1)) & ~stop_req & ~start_req;
    assign go_on    = start_req | ((state == OFF) & phase_last & (rem != CNT_W'(1)) & ~stop_req);
    assign go_off   = (state == ON) & phase_last & ~start_req & ~stop_req;
    assign go_idle  = stop_req | seq_done;

    // Restart the prescaler on every phase boundary so each phase is exactly
    // N whole ticks, and keep it parked while idle.
    assign tick_clear = (state == IDLE) | go_on | go_off | go_idle;

    buzz_tick_div #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .pulse (tick)
    );

`ifdef BUZZ_TONE_EN
    logic tone;
    logic tone_tick;
    logic tone_clear;

    // The tone counter only runs inside an ON phase and restarts at each ON
    // entry so the waveform always begins low with a full half-period.
    assign tone_clear = (state != ON) | go_on | go_off | go_idle;

    buzz_tick_div #(.DIV(TONE_HALF)) u_tone (
        .clk   (clk),
        .reset (reset),
        .clear (tone_clear),
        .pulse (tone_tick)
    );

    assign out_port = {env, tone};
`else
    assign out_port = {env, env};
`endif

    assign irq = done & irq_en;

    // Software-visible configuration registers and the sticky done flag.
    // Completion beats DONE_CLR in the same cycle; START always clears done.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_ticks  <= '0;
            off_ticks <= '0;
            rep_ticks <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    ADDR_ON:  on_ticks  <= bus.writedata[CNT_W-1:0];
                    ADDR_OFF: off_ticks <= bus.writedata[CNT_W-1:0];
                    ADDR_REP: rep_ticks <= bus.writedata[CNT_W-1:0];
                    default:  irq_en    <= bus.writedata[CTRL_IRQ_EN];
                endcase
            end
            if (seq_done) begin
                done <= 1'b1;
            end else if (start_req) begin
                done <= 1'b0;
            end else if (ctrl_wr && bus.writedata[CTRL_DONE_CLR]) begin
                done <= 1'b0;
            end
        end
    end

    // Sequencer FSM with registered envelope (and tone). Phase lengths are
    // re-latched on every ON entry so config changes apply to the next
    // pattern; the repeat count is only reloaded by START.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            on_len    <= '0;
            off_len   <= '0;
            rem       <= '0;
            phase_cnt <= '0;
            env       <= 1'b0;
`ifdef BUZZ_TONE_EN
            tone      <= 1'b0;
`endif
        end else begin
            if (go_idle) begin
                state <= IDLE;
                env   <= 1'b0;
            end else if (go_on) begin
                state   <= ON;
                env     <= 1'b1;
                on_len  <= (on_ticks  == '0) ? CNT_W'(1) : on_ticks;
                off_len <= (off_ticks == '0) ? CNT_W'(1) : off_ticks;
                if (start_req) begin
                    rem <= rep_ticks;
                end else if (rem != '0) begin
                    rem <= rem - CNT_W'(1);
                end
            end else if (go_off) begin
                state <= OFF;
                env   <= 1'b0;
            end

            if (go_on || go_off || go_idle) begin
                phase_cnt <= '0;
            end else if (tick && (state != IDLE)) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end

`ifdef BUZZ_TONE_EN
            if (go_on || go_off || go_idle) begin
                tone <= 1'b0;
            end else if ((state == ON) && tone_tick) begin
                tone <= ~tone;
            end
`endif
        end
    end

    // Zero-wait-state read mux; unused bits read as zero.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                rdata[RD_BUSY]   = (state != IDLE);
                rdata[RD_IRQ_EN] = irq_en;
                rdata[RD_DONE]   = done;
            end
            ADDR_ON:  rdata[CNT_W-1:0] = on_ticks;
            ADDR_OFF: rdata[CNT_W-1:0] = off_ticks;
            default:  rdata[CNT_W-1:0] = rep_ticks;
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_buzz_sequencer.sv
// Directed self-checking bench for buzz_sequencer (TICK_DIV=4, TONE_HALF=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_buzz_sequencer;
    import buzz_pkg::*;

    logic clk;
    logic reset;
    logic [1:0] out_port;
    logic irq;
    int checks;
    int failures;
    logic [31:0] rd;

    buzz_sequencer_if bus_if ();

    buzz_sequencer #(
        .TICK_DIV  (4),
        .TONE_HALF (2),
        .CNT_W     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .out_port (out_port),
        .irq      (irq)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison with failure accounting
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Single-cycle bus write, called at a falling edge; returns at the next one
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus_if.address = addr;
        #1;
        data = bus_if.readdata;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected out_port for cycle j of a phase whose envelope is env
    function automatic logic [1:0] expOut(input int j, input logic env);
`ifdef BUZZ_TONE_EN
        return {env, env ? logic'((j / 2) % 2) : 1'b0};
`else
        return {env, env};
`endif
    endfunction

    // Check len consecutive cycles of one phase starting at phase cycle j0
    task automatic checkPhase(input string tag, input logic env, input int j0, input int len);
        for (int j = j0; j < j0 + len; j++) begin
            checkOutput($sformatf("%s_c%0d", tag, j), 32'(out_port), 32'(expOut(j, env)));
            step(1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;

        // Reset state
        step(3);
        checkOutput("rst_out", 32'(out_port), 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            checkOutput($sformatf("rst_rd%0d", a), rd, 32'd0);
        end
        reset = 1'b0;
        step(1);

        // Basic sequence: ON=2, OFF=3, REPEAT=2 with irq_en
        $display("[TB] basic sequence");
        applyStimulus(ADDR_ON, 32'd2);
        applyStimulus(ADDR_OFF, 32'd3);
        applyStimulus(ADDR_REP, 32'd2);
        applyStimulus(ADDR_CTRL, 32'h5);
        checkPhase("b_on1", 1'b1, 0, 8);
        checkPhase("b_off1", 1'b0, 0, 12);
        checkPhase("b_on2", 1'b1, 0, 8);
        checkPhase("b_off2", 1'b0, 0, 12);
        readReg(ADDR_CTRL, rd);
        checkOutput("b_ctrl_done", rd, 32'hC);
        checkOutput("b_irq", 32'(irq), 32'd1);
        readReg(ADDR_ON, rd);
        checkOutput("b_rd_on", rd, 32'd2);
        readReg(ADDR_OFF, rd);
        checkOutput("b_rd_off", rd, 32'd3);
        readReg(ADDR_REP, rd);
        checkOutput("b_rd_rep", rd, 32'd2);
        step(1);
        applyStimulus(ADDR_CTRL, 32'h8);
        readReg(ADDR_CTRL, rd);
        checkOutput("b_done_clr", rd, 32'd0);
        checkOutput("b_irq_clr", 32'(irq), 32'd0);
        step(1);

        // Infinite mode then STOP
        $display("[TB] infinite and stop");
        applyStimulus(ADDR_REP, 32'd0);
        applyStimulus(ADDR_CTRL, 32'h1);
        step(100);
        checkOutput("inf_out", 32'(out_port), 32'(expOut(0, 1'b1)));
        readReg(ADDR_CTRL, rd);
        checkOutput("inf_busy", rd, 32'h1);
        step(1);
        applyStimulus(ADDR_CTRL, 32'h2);
        checkOutput("stop_out", 32'(out_port), 32'd0);
        readReg(ADDR_CTRL, rd);
        checkOutput("stop_ctrl", rd, 32'd0);
        step(1);

        // Zero lengths behave as one tick
        $display("[TB] zero length");
        applyStimulus(ADDR_ON, 32'd0);
        applyStimulus(ADDR_OFF, 32'd0);
        applyStimulus(ADDR_REP, 32'd1);
        applyStimulus(ADDR_CTRL, 32'h1);
        checkPhase("z_on", 1'b1, 0, 4);
        checkPhase("z_off", 1'b0, 0, 4);
        readReg(ADDR_CTRL, rd);
        checkOutput("z_done", rd, 32'h8);
        readReg(ADDR_ON, rd);
        checkOutput("z_rd_on", rd, 32'd0);
        step(1);
        applyStimulus(ADDR_CTRL, 32'h3);
        checkOutput("ss_out", 32'(out_port), 32'd0);
        readReg(ADDR_CTRL, rd);
        checkOutput("ss_busy", rd & 32'h1, 32'd0);
        step(1);
        checkOutput("ss_out2", 32'(out_port), 32'd0);

        // Restart mid-ON, then ON changed mid-sequence
        $display("[TB] restart mid-phase");
        applyStimulus(ADDR_ON, 32'd2);
        applyStimulus(ADDR_OFF, 32'd3);
        applyStimulus(ADDR_REP, 32'd2);
        applyStimulus(ADDR_CTRL, 32'h1);
        checkPhase("r_on0", 1'b1, 0, 4);
        applyStimulus(ADDR_CTRL, 32'h1);
        applyStimulus(ADDR_ON, 32'd1);
        checkPhase("r_on1", 1'b1, 1, 7);
        checkPhase("r_off1", 1'b0, 0, 12);
        checkPhase("r_on2", 1'b1, 0, 4);
        checkPhase("r_off2", 1'b0, 0, 12);
        readReg(ADDR_CTRL, rd);
        checkOutput("r_done", rd, 32'h8);
        step(1);

        // Synchronous reset in the middle of ON
        $display("[TB] reset mid-on");
        applyStimulus(ADDR_ON, 32'd2);
        applyStimulus(ADDR_REP, 32'd1);
        applyStimulus(ADDR_CTRL, 32'h1);
        step(3);
        reset = 1'b1;
        step(1);
        checkOutput("mr_out", 32'(out_port), 32'd0);
        readReg(ADDR_CTRL, rd);
        checkOutput("mr_ctrl", rd, 32'd0);
        reset = 1'b0;
        step(1);
        readReg(ADDR_ON, rd);
        checkOutput("mr_rd_on", rd, 32'd0);
        step(1);

        // Completion in the same cycle as DONE_CLR keeps done set
        $display("[TB] completion vs done_clr");
        applyStimulus(ADDR_REP, 32'd1);
        applyStimulus(ADDR_CTRL, 32'h5);
        checkPhase("cd_on", 1'b1, 0, 4);
        checkPhase("cd_off", 1'b0, 0, 3);
        applyStimulus(ADDR_CTRL, 32'hC);
        readReg(ADDR_CTRL, rd);
        checkOutput("cd_done", rd, 32'hC);
        checkOutput("cd_irq", 32'(irq), 32'd1);
        checkOutput("cd_out", 32'(out_port), 32'd0);
        step(1);
        applyStimulus(ADDR_CTRL, 32'h9);
        readReg(ADDR_CTRL, rd);
        checkOutput("sd_ctrl", rd, 32'h1);
        checkOutput("sd_irq", 32'(irq), 32'd0);
        step(1);
        applyStimulus(ADDR_CTRL, 32'h2);
        checkOutput("end_out", 32'(out_port), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzz_sequencer.md
Name: buzz_sequencer

Overview:
- Avalon-MM slave that drives the alarm buzzer with a programmable beep cadence. It replaces direct CPU bit-banging of the 2-bit buzzer output.
- Software loads on-time, off-time and repeat count, then writes START. The block sequences the on/off phases autonomously and raises a sticky done flag and IRQ when finished.
- Sits between the Nios data master and the buzzer pins. out_port[0] carries the tone; out_port[1] carries the envelope (enable for an external amp).

Parameters:
- TICK_DIV, 50000: clk cycles per timing tick (1 ms at 50 MHz); minimum 1.
- TONE_HALF, 12500: clk cycles per tone half-period (2 kHz at 50 MHz); minimum 1.
- CNT_W, 16: width of the ON_TICKS, OFF_TICKS and REPEAT registers.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- address, input, 2: register select.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data.
- readdata, output, 32: read data, combinational from address, zero wait states.
- out_port, output, 2: [0] tone, [1] envelope.
- irq, output, 1: level interrupt = done & irq_en.

Behaviour:
- Register map (write = chipselect & ~write_n):
  - 0 CTRL. Write: bit0 START, bit1 STOP, bit2 irq_en, bit3 DONE_CLR. Read: {28'b0, done, irq_en, 1'b0, busy}.
  - 1 ON_TICKS, [CNT_W-1:0].
  - 2 OFF_TICKS, [CNT_W-1:0].
  - 3 REPEAT, [CNT_W-1:0]; 0 means repeat forever.
  - Unused read bits are 0.
- Reset:
  - FSM=IDLE; all registers and counters 0; out_port=2'b00; irq=0.
  - Reset mid-sequence silences out_port on the next edge.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 while FSM≠IDLE; emits a 1-cycle tick at the wrap.
  - Cleared in IDLE and on every phase entry, so each phase lasts exactly N full ticks.
- FSM states: IDLE, ON, OFF.
  - IDLE→ON on a START write. Latch on_len=max(ON_TICKS,1), off_len=max(OFF_TICKS,1), rem=REPEAT. Clear done.
  - ON: envelope=1. After on_len ticks: →OFF.
  - OFF: envelope=0. After off_len ticks:
    - rem==1 → IDLE, set done.
    - rem==0 → ON (infinite mode).
    - otherwise rem-=1, →ON.
  - Phase lengths are re-latched from the registers at each ON entry. Config writes made while busy take effect on the next cycle of the pattern, never mid-phase.
- busy = (FSM≠IDLE).
- Latency:
  - out_port[1] rises the cycle after the START write is accepted.
  - Total sequence = REPEAT×(on_len+off_len)×TICK_DIV cycles, ±1 cycle.
- Tone: while in ON, a half-period counter toggles out_port[0] every TONE_HALF cycles, starting at 0 on ON entry. In OFF and IDLE, out_port[0]=0.
- Simultaneous / boundary events:
  - STOP wins over START in the same write.
  - STOP → IDLE next cycle, outputs 0, done NOT set.
  - START while busy restarts from ON with freshly latched values.
  - DONE_CLR together with sequence completion in the same cycle: done stays set (completion wins).
  - DONE_CLR with START: done=0.
  - irq_en is written on every CTRL write.
- Counters saturate/wrap only at CNT_W. ON_TICKS=0 is treated as 1.

Optional Feature:
- Macro: BUZZ_TONE_EN.
- Defined: tone generator as above (for a passive piezo).
- Undefined: tone counter not built; out_port[0] = envelope (for an active buzzer). TONE_HALF is ignored.

Decomposition:
- Shared package buzz_pkg holds:
  - state enum buzz_state_t {IDLE, ON, OFF};
  - register address constants ADDR_CTRL=0, ADDR_ON=1, ADDR_OFF=2, ADDR_REP=3;
  - CTRL bit-position constants.
- One natural sub-module: buzz_tick_div, a parameterised clear-able divider emitting a 1-cycle pulse. It is instantiated for the tick prescaler and, under BUZZ_TONE_EN, for the tone toggle.

Test Plan (TICK_DIV=4, TONE_HALF=2 in sim):
- Reset: hold reset 3 cycles → out_port=00, irq=0; all reads return 0.
- Basic sequence: ON=2, OFF=3, REPEAT=2, START → envelope high 8 cycles, low 12, high 8, low 12; then busy=0, done=1; irq=1 if irq_en=1. Tone toggles every 2 cycles only in ON.
- Infinite and stop: REPEAT=0, START, run 5 patterns → still busy. Write STOP → out_port=00 next cycle, done=0.
- Zero length: ON=0, OFF=0, REPEAT=1 → envelope high 4 cycles, low 4, done. Write START|STOP together → stays IDLE.
- Restart mid-phase: START, then START again at cycle 5 of ON → ON restarts with a full 8-cycle phase. ON changed to 1 mid-sequence applies only at the next ON entry.
- Sync reset mid-ON: assert reset → next edge out_port=00, busy=0. Completion coincident with DONE_CLR → done remains 1.
